pipe_stage_buffer: RTL and testbench
====================================

Name: pipe_stage_buffer

Overview:
- Parametrised pipeline stage buffer. It is the successor to the fixed decode-stage register set: it replaces the hard-coded field registers plus global stall/flush with a generic WIDTH-bit payload, a DEPTH-entry elastic buffer and a valid/ready handshake on both sides.
- Sits between any two pipeline stages (IF/ID, ID/EX, ...). Bundled control and data fields are concatenated into in_data by the instantiating stage.
- Provides flush-on-redirect and back-pressure decoupling with no combinational ready path through the block.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- DEPTH, 2, number of buffer entries (>=1; need not be a power of 2).
- CW, $clog2(DEPTH+1), count width (derived; not to be overridden).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  buffer can accept; equals (count < DEPTH).
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  head entry valid; equals (count != 0).
- out_ready  input  1  downstream accepts the head entry.
- out_data  output  WIDTH  head entry payload; all-zero whenever out_valid=0.
- count  output  CW  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset. No asynchronous paths.
- Reset values: count=0, in_ready=1, out_valid=0, out_data=0, read/write pointers=0. Entry storage contents are don't-care, but are masked from out_data.
- Handshake events:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - A transfer occurs only in a cycle where both signals of its pair are high at the posedge.
- Latency: a payload pushed at edge N appears on out_data with out_valid=1 after edge N, provided the buffer was empty. There is no same-cycle bypass from in_data to out_data.
- in_ready depends only on registered count. It must not depend combinationally on out_ready.
- Ordering: strict FIFO. Payloads leave in push order with no duplication and no loss unless flushed.
- Occupancy update per edge:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged; write pointer and read pointer both advance.
  - neither: hold.
- Full (count==DEPTH): in_ready=0, so no push is possible. A pop in the same cycle is honoured, and in_ready rises the following cycle.
- Empty (count==0): out_valid=0 and out_data=0. out_ready is ignored.
- Pointer wrap: each pointer increments modulo DEPTH (DEPTH-1 -> 0), including for non-power-of-2 DEPTH.
- DEPTH=1 degenerates to a single register with no combinational bypass. Throughput is then one transfer per two cycles under continuous flow; this is accepted.
- Flush (flush=1 at an edge):
  - count -> 0 and both pointers -> 0.
  - Any push and any pop in the same cycle are discarded; the payload offered that cycle is not stored.
  - The next cycle shows out_valid=0 and out_data=0.
  - in_ready is not forced low during flush.
- Priority: reset > flush > push/pop.
- Reset asserted mid-operation behaves as flush and additionally clears optional counters.
- X-safety: out_data is gated to zero when empty, so stale storage never propagates.

Optional Feature:
- Macro: PIPE_STAGE_BUFFER_PERF_EN.
- Defined: adds two outputs.
  - stall_cycles (output, 32): increments in every cycle with in_valid && !in_ready.
  - flush_drops (output, 32): on a flush edge, adds count plus 1 if in_valid was high that cycle.
  - Both counters saturate at 32'hFFFFFFFF and clear only on reset, not on flush.
- Undefined: ports and counters are absent. Core behaviour is identical.

Test Plan:
- Reset, then idle: after reset=1 for 1 cycle, expect count=0, in_ready=1, out_valid=0, out_data=0; all held for 5 idle cycles.
- Fill and drain (WIDTH=8, DEPTH=3):
  - Push 8'h11, 8'h22, 8'h33 with out_ready=0: count reaches 3 and in_ready=0.
  - A 4th in_valid with 8'h44 is not accepted.
  - Raise out_ready: outputs 11, 22, 33 in order, then out_valid=0. 8'h44 enters only after in_ready returns.
- Streaming with wrap (DEPTH=3): continuous in_valid/out_ready with 10 payloads 0x01..0x0A.
  - Expect in-order output, each payload one cycle after its push.
  - count stays at 1 throughout.
  - Pointers wrap at least 3 times.
- Simultaneous push/pop when full (DEPTH=3, holding A,B,C):
  - out_ready=1 and in_valid=1 with D: C... pops A, does not accept D, count goes to 2.
  - Next cycle: D is accepted, count stays 2 with the concurrent pop of B, and the remaining order is C, D.
- Flush mid-stream: buffer holding 0x11,0x22, with flush=1, in_valid=1 (0x33) and out_ready=1 in the same cycle.
  - Next cycle: count=0, out_valid=0, out_data=0; nothing is delivered.
  - With PIPE_STAGE_BUFFER_PERF_EN: flush_drops=3.
- Perf counters (macro defined, DEPTH=2): hold in_valid=1 with out_ready=0 for 10 cycles.
  - stall_cycles=8.
  - Reset returns the counter to 0; a flush alone leaves it at 8.

Source files
------------

// File: rtl/pipe_stage_buffer_if.sv
// pipe_stage_buffer_if
//   Handshake bundle for pipe_stage_buffer. It groups both the upstream
//   (in_*) and the downstream (out_*) valid/ready/data channels.
//   Parameter WIDTH: payload width in bits.
//   Signals:
//     in_valid  / in_ready  / in_data   : upstream producer -> buffer
//     out_valid / out_ready / out_data  : buffer -> downstream consumer
//   Modports:
//     slave  : the buffer side (accepts in_*, produces out_*)
//     master : the surrounding pipeline (produces in_*, consumes out_*)
interface pipe_stage_buffer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data
  );
endinterface

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer
//   Generic elastic pipeline stage: a DEPTH-entry FIFO carrying a WIDTH-bit
//   payload, with valid/ready handshakes on both sides and a synchronous
//   flush for pipeline redirects. in_ready is derived only from the
//   registered occupancy, so no combinational ready path crosses the block.
//   out_data is forced to zero whenever the buffer is empty.
// Parameters:
//   WIDTH : payload width (>=1)
//   DEPTH : number of entries (>=1, any value, not only powers of two)
//   CW    : occupancy width, derived as $clog2(DEPTH+1); do not override
// Ports:
//   clk    : clock, all state changes on posedge
//   reset  : synchronous active-high reset
//   flush  : synchronous discard of every buffered entry
//   bus    : pipe_stage_buffer_if.slave (in_valid/in_ready/in_data,
//            out_valid/out_ready/out_data)
//   count  : current occupancy 0..DEPTH
// Optional build macro PIPE_STAGE_BUFFER_PERF_EN adds:
//   stall_cycles : cycles with in_valid && !in_ready (saturating)
//   flush_drops  : payloads discarded by flushes (saturating)
//   Both clear only on reset.
module pipe_stage_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_buffer_if.slave bus,
  output logic [CW-1:0]    count
`ifdef PIPE_STAGE_BUFFER_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_drops
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             wr_en;

  // Modulo-DEPTH increment; explicit compare so non-power-of-2 depths wrap.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PW'(1);
  endfunction

  // Saturating 32-bit accumulate for the event counters.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  // Handshake decode from registered occupancy
  assign bus.in_ready  = (count < CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

  assign push  = bus.in_valid  && bus.in_ready;
  assign pop   = bus.out_valid && bus.out_ready;
  assign wr_en = push && !flush && !reset;

  // Control state: occupancy and pointers
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage, not reset; stale entries are masked at out_data
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

`ifdef PIPE_STAGE_BUFFER_PERF_EN
  // Event counters survive flush; only reset clears them
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_drops  <= '0;
    end else begin
      if (bus.in_valid && !bus.in_ready) begin
        stall_cycles <= sat_add(stall_cycles, 32'd1);
      end
      if (flush) begin
        flush_drops <= sat_add(flush_drops,
                               32'(count) + 32'(bus.in_valid));
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb_pipe_stage_buffer
//   Self-checking bench for pipe_stage_buffer (WIDTH=8, DEPTH=3). A queue
//   holds the expected buffer contents; directed scenarios plus a random
//   phase compare the DUT outputs against it.
module tb_pipe_stage_buffer;
  localparam int W   = 8;
  localparam int D   = 3;
  localparam int CWT = $clog2(D + 1);

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic           flush = 1'b0;
  logic [CWT-1:0] count;

  pipe_stage_buffer_if #(.WIDTH(W)) bus ();

`ifdef PIPE_STAGE_BUFFER_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_drops;
`endif

  pipe_stage_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .bus          (bus),
    .count        (count)
`ifdef PIPE_STAGE_BUFFER_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_drops  (flush_drops)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] mq [$];
  longint       m_stall = 0;
  longint       m_drops = 0;

  // Advance one clock edge, updating the reference model from the inputs
  // that are presented during that edge.
  task automatic tick();
    int sz;
    bit do_push, do_pop;
    sz      = mq.size();
    do_push = bus.in_valid && (sz < D);
    do_pop  = (sz != 0) && bus.out_ready;
    if (reset) begin
      m_stall = 0;
      m_drops = 0;
    end else begin
      if (bus.in_valid && sz >= D && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (flush) begin
        m_drops = m_drops + sz + (bus.in_valid ? 1 : 0);
        if (m_drops > 64'hFFFF_FFFF) m_drops = 64'hFFFF_FFFF;
      end
    end
    if (reset || flush) begin
      mq.delete();
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(bus.in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    tick();
    bus.in_data  = 8'h6B;
    tick();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (count !== 0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
          bus.out_data !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: count=%0d in_ready=%b out_valid=%b out_data=%02h, want 0/1/0/00",
                 i, count, bus.in_ready, bus.out_valid, bus.out_data);
      end
      tick();
    end
`ifdef PIPE_STAGE_BUFFER_PERF_EN
    n_tests++;
    if (stall_cycles !== 32'd0 || flush_drops !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_perf: stall=%0d drops=%0d, want 0/0", stall_cycles, flush_drops);
    end
`endif
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] vals [3];
    logic [W-1:0] want [4];
    logic [W-1:0] got [$];
    int acc_cycle;
    vals = '{8'h11, 8'h22, 8'h33};
    want = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    foreach (vals[i]) begin
      bus.in_data = vals[i];
      tick();
    end
    n_tests++;
    if (count !== 3 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: count=%0d in_ready=%b, want 3/0", count, bus.in_ready);
    end
    bus.in_data = 8'h44;
    tick();
    n_tests++;
    if (count !== 3 || bus.out_data !== 8'h11) begin
      n_fail++;
      $display("FAIL fill_reject: count=%0d head=%02h, want 3/11", count, bus.out_data);
    end
    bus.out_ready = 1'b1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready_comb: in_ready=%b, want 0", bus.in_ready);
    end
    acc_cycle = -1;
    for (int c = 0; c < 12 && got.size() < 4; c++) begin
      bit took;
      took = 1'b0;
      if (bus.out_valid) got.push_back(bus.out_data);
      if (bus.in_valid && bus.in_ready) begin
        acc_cycle = c;
        took = 1'b1;
      end
      tick();
      if (took) bus.in_valid = 1'b0;
    end
    n_tests++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL drain_len: got %0d items, want 4", got.size());
    end else begin
      foreach (want[i]) begin
        n_tests++;
        if (got[i] !== want[i]) begin
          n_fail++;
          $display("FAIL drain_order[%0d]: got %02h want %02h", i, got[i], want[i]);
        end
      end
    end
    n_tests++;
    if (acc_cycle != 1) begin
      n_fail++;
      $display("FAIL late_accept: 44 accepted at cycle %0d, want 1", acc_cycle);
    end
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL drain_empty: out_valid=%b out_data=%02h, want 0/00", bus.out_valid, bus.out_data);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stream();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      bus.in_data = W'(i);
      if (i > 1) begin
        n_tests++;
        if (count !== 1 || bus.out_valid !== 1'b1 || bus.out_data !== W'(i - 1)) begin
          n_fail++;
          $display("FAIL stream[%0d]: count=%0d valid=%b data=%02h, want 1/1/%02h",
                   i, count, bus.out_valid, bus.out_data, W'(i - 1));
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    n_tests++;
    if (count !== 1 || bus.out_data !== 8'h0A) begin
      n_fail++;
      $display("FAIL stream_last: count=%0d data=%02h, want 1/0a", count, bus.out_data);
    end
    tick();
    n_tests++;
    if (count !== 0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: count=%0d valid=%b, want 0/0", count, bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_full_pushpop();
    logic [W-1:0] vals [3];
    vals = '{8'hAA, 8'hBB, 8'hCC};
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    foreach (vals[i]) begin
      bus.in_data = vals[i];
      tick();
    end
    bus.in_data   = 8'hDD;
    bus.out_ready = 1'b1;
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.out_data !== 8'hAA) begin
      n_fail++;
      $display("FAIL fullpp_pre: in_ready=%b head=%02h, want 0/aa", bus.in_ready, bus.out_data);
    end
    tick();
    n_tests++;
    if (count !== 2 || bus.out_data !== 8'hBB || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fullpp_pop: count=%0d head=%02h in_ready=%b, want 2/bb/1",
               count, bus.out_data, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_tests++;
    if (count !== 2 || bus.out_data !== 8'hCC) begin
      n_fail++;
      $display("FAIL fullpp_both: count=%0d head=%02h, want 2/cc", count, bus.out_data);
    end
    tick();
    n_tests++;
    if (count !== 1 || bus.out_data !== 8'hDD) begin
      n_fail++;
      $display("FAIL fullpp_tail: count=%0d head=%02h, want 1/dd", count, bus.out_data);
    end
    tick();
    n_tests++;
    if (count !== 0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpp_empty: count=%0d valid=%b, want 0/0", count, bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    tick();
    bus.in_data   = 8'h22;
    tick();
    bus.in_data   = 8'h33;
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready: in_ready=%b, want 1", bus.in_ready);
    end
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    n_tests++;
    if (count !== 0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL flush_clear: count=%0d valid=%b data=%02h, want 0/0/00",
               count, bus.out_valid, bus.out_data);
    end
`ifdef PIPE_STAGE_BUFFER_PERF_EN
    n_tests++;
    if (flush_drops !== 32'd3) begin
      n_fail++;
      $display("FAIL flush_drops: got %0d want 3", flush_drops);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_nodeliver[%0d]: out_valid=%b, want 0", i, bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
  endtask

`ifdef PIPE_STAGE_BUFFER_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = W'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    n_tests++;
    if (stall_cycles !== 32'(10 - D)) begin
      n_fail++;
      $display("FAIL perf_stall: got %0d want %0d", stall_cycles, 10 - D);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (stall_cycles !== 32'(10 - D) || flush_drops !== 32'(D)) begin
      n_fail++;
      $display("FAIL perf_flush: stall=%0d drops=%0d, want %0d/%0d",
               stall_cycles, flush_drops, 10 - D, D);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if (stall_cycles !== 32'd0 || flush_drops !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset: stall=%0d drops=%0d, want 0/0", stall_cycles, flush_drops);
    end
  endtask
`endif

  task automatic test_random();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [W-1:0] exp_data;
      int sz;
      sz       = mq.size();
      exp_data = (sz != 0) ? mq[0] : '0;
      n_tests++;
      if (count !== CWT'(sz) || bus.in_ready !== (sz < D) ||
          bus.out_valid !== (sz != 0) || bus.out_data !== exp_data) begin
        n_fail++;
        $display("FAIL random[%0d]: count=%0d rdy=%b vld=%b data=%02h, want %0d/%b/%b/%02h",
                 c, count, bus.in_ready, bus.out_valid, bus.out_data,
                 sz, (sz < D), (sz != 0), exp_data);
      end
`ifdef PIPE_STAGE_BUFFER_PERF_EN
      n_tests++;
      if (stall_cycles !== 32'(m_stall) || flush_drops !== 32'(m_drops)) begin
        n_fail++;
        $display("FAIL random_perf[%0d]: stall=%0d drops=%0d, want %0d/%0d",
                 c, stall_cycles, flush_drops, m_stall, m_drops);
      end
`endif
      // Alternate bias so the buffer spends time both near full and near empty.
      if ((c / 50) % 2 == 0) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) == 0);
      end else begin
        bus.in_valid  = ($urandom_range(0, 2) == 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      bus.in_data = W'($urandom);
      flush       = ($urandom_range(0, 24) == 0);
      reset       = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_fill_drain();
    test_stream();
    test_full_pushpop();
    test_flush();
`ifdef PIPE_STAGE_BUFFER_PERF_EN
    test_perf();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule
